// File: rtl/parking_pkg.sv
// Shared types and constants for the parking-lot occupancy counter.
package parking_pkg;

  localparam int unsigned CNT_W    = 3;
  localparam int unsigned LED_W    = CNT_W + 1;
  localparam int unsigned LED_FULL = 3;

  // Direction decoder states; ENT_* track an entry, EXT_* an exit.
  typedef enum logic [2:0] {
    IDLE,
    ENT_A,
    ENT_AB,
    ENT_B,
    EXT_B,
    EXT_AB,
    EXT_A,
    WAIT_CLR
  } park_state_e;

endpackage

// File: rtl/parking_debounce.sv
// Two-flop synchroniser plus stable-count filter for one barrier sensor.
// The filter is present only when PARKING_DEBOUNCE_EN is defined.
module parking_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pin};
    end
  end

`ifdef PARKING_DEBOUNCE_EN
  localparam int unsigned STB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(DEBOUNCE_CYCLES - 1);

  logic [STB_W-1:0] stb_q;
  logic             level_q;

  // Level follows the synchronised input only after DEBOUNCE_CYCLES differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_q   <= '0;
      level_q <= 1'b0;
    end else if (sync_q[1] == level_q) begin
      stb_q <= '0;
    end else if (stb_q == STB_LAST) begin
      stb_q   <= '0;
      level_q <= sync_q[1];
    end else begin
      stb_q <= stb_q + STB_W'(1);
    end
  end

  assign level = level_q;
`else
  assign level = sync_q[1];
`endif

endmodule

// File: rtl/estacionamiento_top.sv
// Parking-lot occupancy counter: sensor conditioning, direction FSM, saturating count, LEDs.
// Optional input debouncing is enabled by defining PARKING_DEBOUNCE_EN.
module estacionamiento_top
  import parking_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned CAPACITY        = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_A,
  input  logic             btn_B,
  output logic [LED_W-1:0] leds
);

  logic        a;
  logic        b;
  logic [1:0]  pat;
  park_state_e state_q;
  park_state_e state_d;
  logic        entry_d;
  logic        exit_d;
  logic        entry_q;
  logic        exit_q;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic [LED_W-1:0] leds_q;

  parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk   (clk),
    .rst_n (rst),
    .pin   (btn_A),
    .level (a)
  );

  parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk   (clk),
    .rst_n (rst),
    .pin   (btn_B),
    .level (b)
  );

  assign pat = {a, b};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      entry_q <= 1'b0;
      exit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      exit_q  <= exit_d;
    end
  end

  // Each state stays put on its own pattern; anything unexpected parks in WAIT_CLR.
  always_comb begin
    state_d = state_q;
    entry_d = 1'b0;
    exit_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        case (pat)
          2'b00:   state_d = IDLE;
          2'b10:   state_d = ENT_A;
          2'b01:   state_d = EXT_B;
          default: state_d = WAIT_CLR;
        endcase
      end
      ENT_A: begin
        case (pat)
          2'b10:   state_d = ENT_A;
          2'b11:   state_d = ENT_AB;
          2'b00:   state_d = IDLE;
          default: state_d = WAIT_CLR;
        endcase
      end
      ENT_AB: begin
        case (pat)
          2'b11:   state_d = ENT_AB;
          2'b01:   state_d = ENT_B;
          2'b10:   state_d = ENT_A;
          default: state_d = WAIT_CLR;
        endcase
      end
      ENT_B: begin
        case (pat)
          2'b01:   state_d = ENT_B;
          2'b00: begin
            state_d = IDLE;
            entry_d = 1'b1;
          end
          2'b11:   state_d = ENT_AB;
          default: state_d = WAIT_CLR;
        endcase
      end
      EXT_B: begin
        case (pat)
          2'b01:   state_d = EXT_B;
          2'b11:   state_d = EXT_AB;
          2'b00:   state_d = IDLE;
          default: state_d = WAIT_CLR;
        endcase
      end
      EXT_AB: begin
        case (pat)
          2'b11:   state_d = EXT_AB;
          2'b10:   state_d = EXT_A;
          2'b01:   state_d = EXT_B;
          default: state_d = WAIT_CLR;
        endcase
      end
      EXT_A: begin
        case (pat)
          2'b10:   state_d = EXT_A;
          2'b00: begin
            state_d = IDLE;
            exit_d  = 1'b1;
          end
          2'b11:   state_d = EXT_AB;
          default: state_d = WAIT_CLR;
        endcase
      end
      WAIT_CLR: begin
        if (pat == 2'b00) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign full = (count_q == CNT_W'(CAPACITY));

  // Saturating occupancy counter; pulses at the limits are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (entry_q && !full) begin
      count_q <= count_q + CNT_W'(1);
    end else if (exit_q && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      leds_q <= '0;
    end else begin
      leds_q[LED_FULL]    <= full;
      leds_q[CNT_W-1:0]   <= count_q;
    end
  end

  assign leds = leds_q;

endmodule

// File: tb/tb_estacionamiento_top.sv
// Directed bench for estacionamiento_top: table of sensor sequences plus reset/glitch/latency cases.
module tb_estacionamiento_top;
  import parking_pkg::*;

  localparam int unsigned DB     = 16;
  localparam int unsigned HOLD   = 40;
  localparam int unsigned GLITCH = 8;
`ifdef PARKING_DEBOUNCE_EN
  localparam int unsigned LAT = DB + 5;
`else
  localparam int unsigned LAT = 5;
`endif

  logic       clk;
  logic       rst;
  logic       btn_A;
  logic       btn_B;
  logic [3:0] leds;

  int tests;
  int errors;

  estacionamiento_top #(.DEBOUNCE_CYCLES(DB), .CAPACITY(7)) dut (
    .clk   (clk),
    .rst   (rst),
    .btn_A (btn_A),
    .btn_B (btn_B),
    .leds  (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  pat [6];
    int unsigned n;
    logic [3:0]  exp_leds;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic [1:0] p0, input logic [1:0] p1, input logic [1:0] p2,
                              input logic [1:0] p3, input logic [1:0] p4, input logic [1:0] p5,
                              input int unsigned n, input logic [3:0] e);
    vec_t v;
    v.pat[0] = p0; v.pat[1] = p1; v.pat[2] = p2;
    v.pat[3] = p3; v.pat[4] = p4; v.pat[5] = p5;
    v.n = n;
    v.exp_leds = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] p, input int unsigned cycles);
    {btn_A, btn_B} = p;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic run_seq(input vec_t v);
    for (int k = 0; k < int'(v.n); k++) drive(v.pat[k], HOLD);
  endtask

  initial begin
    tests  = 0;
    errors = 0;
    rst    = 1'b0;
    btn_A  = 1'b0;
    btn_B  = 1'b0;

    // Entry/exit and abort patterns; expected leds = {full, count}.
    vecs[0]  = mk(2'b10, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 4, 4'b0001);
    vecs[1]  = mk(2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 4, 4'b0000);
    vecs[2]  = mk(2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 4, 4'b0000);
    vecs[3]  = mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2, 4'b0000);
    vecs[4]  = mk(2'b10, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 4, 4'b0000);
    vecs[5]  = mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      vecs[6+i] = mk(2'b10, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 4,
                     (i >= 6) ? 4'b1111 : 4'(i + 1));
    end
    vecs[14] = mk(2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 4, 4'b0110);
    vecs[15] = mk(2'b01, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 4, 4'b0110);
    vecs[16] = mk(2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3, 4'b0110);
    vecs[17] = mk(2'b10, 2'b11, 2'b01, 2'b11, 2'b01, 2'b00, 6, 4'b1111);

    repeat (3) @(negedge clk);
    check("reset_leds", leds, 4'b0000);
    check("reset_state", 4'(dut.state_q), 4'(IDLE));
    rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      run_seq(vecs[i]);
      check($sformatf("vec%0d_leds", i), leds, vecs[i].exp_leds);
      check($sformatf("vec%0d_idle", i), 4'(dut.state_q), 4'(IDLE));
    end

    // Exact pin-to-leds latency of the final clear of an exit from full.
    drive(2'b01, HOLD);
    drive(2'b11, HOLD);
    drive(2'b10, HOLD);
    drive(2'b00, LAT - 1);
    check("latency_before", leds, 4'b1111);
    @(negedge clk);
    check("latency_after", leds, 4'b0110);
    drive(2'b00, HOLD);

    // Short pulse on A.
    drive(2'b10, 6);
`ifdef PARKING_DEBOUNCE_EN
    check("glitch_state", 4'(dut.state_q), 4'(IDLE));
`else
    check("glitch_state", 4'(dut.state_q), 4'(ENT_A));
`endif
    drive(2'b10, GLITCH - 6);
    drive(2'b00, HOLD);
    check("glitch_idle", 4'(dut.state_q), 4'(IDLE));
    check("glitch_leds", leds, 4'b0110);

    // Down to count 3, then reset in the middle of an entry.
    for (int i = 0; i < 3; i++) run_seq(vecs[1]);
    check("pre_rst_leds", leds, 4'b0011);
    drive(2'b10, HOLD);
    drive(2'b11, HOLD);
    check("pre_rst_state", 4'(dut.state_q), 4'(ENT_AB));
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_leds", leds, 4'b0000);
    check("async_rst_state", 4'(dut.state_q), 4'(IDLE));
    btn_A = 1'b0;
    btn_B = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    drive(2'b00, HOLD);
    check("post_rst_leds", leds, 4'b0000);
    run_seq(vecs[0]);
    check("post_rst_entry", leds, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
